hazard_encode_ctrl: RTL and testbench
=====================================

HAZARD_ENCODE_CTRL -- requirements
Module: hazard_encode_ctrl

Interface
REQ-001 Parameter CELL_SHIFT, default 7: cell edge is 2^CELL_SHIFT pixels; cell index = coordinate >> CELL_SHIFT.
REQ-002 Parameter GRID_COLS, default 8: columns per grid row.
REQ-003 Parameter GRID_ROWS, default 4: grid rows; rows 0-1 map to vec1, rows 2-3 map to vec2.
REQ-004 Port clk, input, 1: single clock; all state SHALL change on its rising edge only.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: begin a frame; sampled only in IDLE.
REQ-007 Port num_hazards, input, 4: hazard count for the frame, latched on an accepted start.
REQ-008 Port hz_valid, input, 1: a hazard box is present on hz_top, hz_left, hz_bottom and hz_right.
REQ-009 Port hz_ready, output, 1: the block accepts a box; a beat transfers when hz_valid and hz_ready are both high.
REQ-010 Ports hz_top, hz_left, hz_bottom, hz_right, input, 11 each: box edges in pixels, inclusive.
REQ-011 Port vec1, output, 16: occupancy of rows 0-1; bit = (row%2)*8 + col.
REQ-012 Port vec2, output, 16: occupancy of rows 2-3, same bit mapping.
REQ-013 Port vec_valid, output, 1: one-cycle pulse when vec1/vec2 update.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port bad_count, output, 4: count of malformed boxes in the last frame.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-017 IDLE: on start with num_hazards > 0, latch the count, clear the accumulator and bad_count, then enter LOAD.
REQ-018 IDLE: on start with num_hazards = 0, clear the accumulator and enter DONE.
REQ-019 LOAD: hz_ready SHALL be high while accepted beats < latched count, and low in all other states.
REQ-020 LOAD: after the beat that brings accepted beats up to the count, enter DRAIN.
REQ-021 Gaps in hz_valid SHALL stall LOAD with no timeout.
REQ-022 Pipeline stage 1 SHALL register the clipped row/col ranges of each accepted beat.
REQ-023 Pipeline stage 2 SHALL OR the cell mask into the 32-bit accumulator.
REQ-024 DRAIN SHALL last until stage 2 has absorbed the last beat, then go to DONE.
REQ-025 DONE: copy the accumulator to vec1/vec2, pulse vec_valid for one cycle, and return to IDLE.
REQ-026 vec_valid SHALL assert exactly 3 cycles after the edge accepting the last beat.
REQ-027 For num_hazards = 0, vec_valid SHALL assert 1 cycle after the start edge.
REQ-028 vec1/vec2 SHALL hold their values until the next DONE.
REQ-029 Range: rows from top>>CELL_SHIFT to min(bottom>>CELL_SHIFT, GRID_ROWS-1); cols from left>>CELL_SHIFT to min(right>>CELL_SHIFT, GRID_COLS-1); both inclusive.
REQ-030 A box with row start ≥ GRID_ROWS or col start ≥ GRID_COLS SHALL add no cells and is not malformed.
REQ-031 A box with bottom < top or right < left is malformed: it SHALL add no cells and SHALL increment bad_count, saturating at 15.
REQ-032 start outside IDLE SHALL be ignored.

Reset
REQ-033 rst SHALL force IDLE and clear the beat counter, both pipeline stages and the accumulator.
REQ-034 rst SHALL drive vec1=0, vec2=0, vec_valid=0, hz_ready=0, busy=0 and bad_count=0 on the next edge, including mid-frame.

Structure
REQ-035 Package hazard_pkg SHALL hold CELL_SHIFT, GRID_COLS, GRID_ROWS, the coordinate width (11) and the FSM state enumeration.
REQ-036 Sub-module hazard_cell_mask SHALL be combinational: clipped ranges in, 32-bit cell mask out.

Verification
REQ-037 num=2, boxes (t10,l20,b200,r300) and (t300,l900,b900,r1230) -> vec1=0x0707, vec2=0x8080, bad_count=0.
REQ-038 num=0 -> vec_valid 1 cycle after start, vec1=vec2=0.
REQ-039 num=3 with one box t200,b100 -> that box contributes nothing, bad_count=1.
REQ-040 Off-grid box l1100 alone -> vec1=vec2=0, bad_count=0.
REQ-041 Scenario REQ-037 with hz_valid toggling every other cycle -> identical vectors; vec_valid 3 cycles after the last accept.
REQ-042 rst after one beat of a 2-box frame, then start repeated during a new frame -> all outputs zero after rst; the second start is ignored; the new frame's result is correct.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and FSM state type for the hazard encoder.
//   CELL_SHIFT  log2 of the cell edge in pixels
//   GRID_COLS   cells per grid row
//   GRID_ROWS   grid rows (rows 0-1 -> vec1, rows 2-3 -> vec2)
//   COORD_W     pixel coordinate width
//   CNT_W       width of the per-frame hazard count
package hazard_pkg;

  localparam int CELL_SHIFT = 7;
  localparam int GRID_COLS  = 8;
  localparam int GRID_ROWS  = 4;
  localparam int COORD_W    = 11;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_encode_ctrl_if.sv
// hazard_encode_ctrl_if: valid/ready hazard-box stream.
//   hz_valid                 box present (master -> slave)
//   hz_ready                 slave accepts a box (slave -> master)
//   hz_top/left/bottom/right inclusive box edges in pixels (master -> slave)
interface hazard_encode_ctrl_if;
  import hazard_pkg::*;

  logic               hz_valid;
  logic               hz_ready;
  logic [COORD_W-1:0] hz_top;
  logic [COORD_W-1:0] hz_left;
  logic [COORD_W-1:0] hz_bottom;
  logic [COORD_W-1:0] hz_right;

  modport master (
    output hz_valid, hz_top, hz_left, hz_bottom, hz_right,
    input  hz_ready
  );

  modport slave (
    input  hz_valid, hz_top, hz_left, hz_bottom, hz_right,
    output hz_ready
  );

endinterface

// File: rtl/hazard_cell_mask.sv
// hazard_cell_mask: combinational cell mask from clipped row/col ranges.
//   en                 box contributes cells
//   row_lo..row_hi     inclusive row range (already clipped to the grid)
//   col_lo..col_hi     inclusive column range (already clipped to the grid)
//   mask               one bit per cell, bit = row*GRID_COLS + col
module hazard_cell_mask #(
  parameter int GRID_ROWS = hazard_pkg::GRID_ROWS,
  parameter int GRID_COLS = hazard_pkg::GRID_COLS,
  parameter int IDX_W     = hazard_pkg::COORD_W - hazard_pkg::CELL_SHIFT
) (
  input  logic                           en,
  input  logic [IDX_W-1:0]               row_lo,
  input  logic [IDX_W-1:0]               row_hi,
  input  logic [IDX_W-1:0]               col_lo,
  input  logic [IDX_W-1:0]               col_hi,
  output logic [GRID_ROWS*GRID_COLS-1:0] mask
);
  import hazard_pkg::*;

  logic [GRID_ROWS-1:0] row_hit;
  logic [GRID_COLS-1:0] col_hit;

  always_comb begin
    row_hit = '0;
    col_hit = '0;
    mask    = '0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      row_hit[r] = (row_lo <= IDX_W'(r)) && (row_hi >= IDX_W'(r));
    end
    for (int c = 0; c < GRID_COLS; c++) begin
      col_hit[c] = (col_lo <= IDX_W'(c)) && (col_hi >= IDX_W'(c));
    end
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        mask[r*GRID_COLS + c] = en && row_hit[r] && col_hit[c];
      end
    end
  end

endmodule

// File: rtl/hazard_encode_ctrl.sv
// hazard_encode_ctrl: accumulates hazard boxes of a frame into a cell
// occupancy grid and publishes it as two 16-bit row-pair vectors.
//   clk, rst       clock, synchronous active-high reset
//   start          begin a frame (sampled in IDLE only)
//   num_hazards    boxes in the frame, latched on an accepted start
//   hz             box stream (slave side)
//   vec1, vec2     occupancy of rows 0-1 / rows 2-3, bit = (row%2)*8 + col
//   vec_valid      one-cycle pulse when vec1/vec2 update
//   busy           high outside IDLE
//   bad_count      malformed boxes seen in the last frame (saturating)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_LOAD  | accepting boxes until the latched count is reached
// ST_DRAIN | waiting for the last box to reach the accumulator
// ST_DONE  | publish the accumulator, pulse vec_valid
module hazard_encode_ctrl #(
  parameter int CELL_SHIFT = hazard_pkg::CELL_SHIFT,
  parameter int GRID_COLS  = hazard_pkg::GRID_COLS,
  parameter int GRID_ROWS  = hazard_pkg::GRID_ROWS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             num_hazards,
  hazard_encode_ctrl_if.slave    hz,
  output logic [15:0]            vec1,
  output logic [15:0]            vec2,
  output logic                   vec_valid,
  output logic                   busy,
  output logic [3:0]             bad_count
);
  import hazard_pkg::*;

  localparam int IDX_W = COORD_W - CELL_SHIFT;
  localparam int CELLS = GRID_ROWS * GRID_COLS;
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(GRID_ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(GRID_COLS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remain;
  logic             accept;
  logic             frame_go;
  logic             frame_empty;

  logic [IDX_W-1:0] row_lo_c, row_end_c, row_hi_c;
  logic [IDX_W-1:0] col_lo_c, col_end_c, col_hi_c;
  logic             malformed_c, off_grid_c;

  logic             s1_valid, s1_bad, s1_en;
  logic [IDX_W-1:0] s1_row_lo, s1_row_hi, s1_col_lo, s1_col_hi;
  logic [CELLS-1:0] cell_mask;
  logic [CELLS-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hz.hz_ready = 1'b0;
    busy        = 1'b1;
    frame_go    = 1'b0;
    frame_empty = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_hazards != '0) begin
            frame_go  = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            frame_empty = 1'b1;
            state_nxt   = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        // remain never reaches zero while in LOAD, so ready is simply the state
        hz.hz_ready = 1'b1;
        if (hz.hz_valid && remain == CNT_W'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // once stage 1 is empty the accumulator holds every box of the frame
        if (!s1_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = hz.hz_valid && hz.hz_ready;

  always_comb begin
    row_lo_c    = hz.hz_top[COORD_W-1:CELL_SHIFT];
    row_end_c   = hz.hz_bottom[COORD_W-1:CELL_SHIFT];
    col_lo_c    = hz.hz_left[COORD_W-1:CELL_SHIFT];
    col_end_c   = hz.hz_right[COORD_W-1:CELL_SHIFT];
    row_hi_c    = (row_end_c > ROW_LAST) ? ROW_LAST : row_end_c;
    col_hi_c    = (col_end_c > COL_LAST) ? COL_LAST : col_end_c;
    malformed_c = (hz.hz_bottom < hz.hz_top) || (hz.hz_right < hz.hz_left);
    off_grid_c  = (row_lo_c > ROW_LAST) || (col_lo_c > COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_bad    <= 1'b0;
      s1_en     <= 1'b0;
      s1_row_lo <= '0;
      s1_row_hi <= '0;
      s1_col_lo <= '0;
      s1_col_hi <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_bad    <= malformed_c;
        // a malformed box is counted but never painted, even if its start is on-grid
        s1_en     <= !malformed_c && !off_grid_c;
        s1_row_lo <= row_lo_c;
        s1_row_hi <= row_hi_c;
        s1_col_lo <= col_lo_c;
        s1_col_hi <= col_hi_c;
      end
    end
  end

  hazard_cell_mask #(
    .GRID_ROWS (GRID_ROWS),
    .GRID_COLS (GRID_COLS),
    .IDX_W     (IDX_W)
  ) u_cell_mask (
    .en     (s1_en),
    .row_lo (s1_row_lo),
    .row_hi (s1_row_hi),
    .col_lo (s1_col_lo),
    .col_hi (s1_col_hi),
    .mask   (cell_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      remain    <= '0;
      acc       <= '0;
      bad_count <= '0;
      vec1      <= '0;
      vec2      <= '0;
      vec_valid <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      if (frame_go)    remain <= num_hazards;
      else if (accept) remain <= remain - CNT_W'(1);

      // bad_count describes the most recent frame, so every accepted start clears it
      if (frame_go || frame_empty) begin
        acc       <= '0;
        bad_count <= '0;
      end else if (s1_valid) begin
        acc <= acc | cell_mask;
        if (s1_bad && bad_count != 4'hF) bad_count <= bad_count + 4'd1;
      end

      if (state == ST_DONE) begin
        vec1      <= acc[15:0];
        vec2      <= acc[31:16];
        vec_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_encode_ctrl.sv
// tb_hazard_encode_ctrl: directed and randomized frames against a
// cell-overlap reference model of the hazard encoder.
module tb_hazard_encode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_hazards;
  logic [15:0] vec1, vec2;
  logic        vec_valid, busy;
  logic [3:0]  bad_count;

  hazard_encode_ctrl_if hz_if ();

  hazard_encode_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_hazards (num_hazards),
    .hz          (hz_if),
    .vec1        (vec1),
    .vec2        (vec2),
    .vec_valid   (vec_valid),
    .busy        (busy),
    .bad_count   (bad_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [10:0] bt [16];
  logic [10:0] bl [16];
  logic [10:0] bb [16];
  logic [10:0] br [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_box(input int i, input int t, input int l, input int b, input int r);
    bt[i] = 11'(t);
    bl[i] = 11'(l);
    bb[i] = 11'(b);
    br[i] = 11'(r);
  endtask

  // A cell (r,c) spans pixels [r*128, r*128+127] x [c*128, c*128+127]; a
  // well-formed box occupies every cell its pixel rectangle overlaps.
  function automatic void model_frame(input int n, output logic [31:0] v, output logic [3:0] bad);
    int nb;
    nb = 0;
    v  = '0;
    for (int i = 0; i < n; i++) begin
      if (bb[i] < bt[i] || br[i] < bl[i]) begin
        if (nb < 15) nb++;
      end else begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 8; c++) begin
            if (int'(bt[i]) <= r*128 + 127 && int'(bb[i]) >= r*128 &&
                int'(bl[i]) <= c*128 + 127 && int'(br[i]) >= c*128)
              v[r*8 + c] = 1'b1;
          end
        end
      end
    end
    bad = 4'(nb);
  endfunction

  // Called and returning at #1 after a rising edge with the DUT in IDLE.
  task automatic run_frame(input int n, input bit gappy, input bit poke, input string tag);
    logic [31:0] ev;
    logic [3:0]  eb;
    int          idx, guard, lat;
    bit          v, w;
    model_frame(n, ev, eb);
    start       = 1'b1;
    num_hazards = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 400) begin
      v = gappy ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
      hz_if.hz_valid  = v;
      hz_if.hz_top    = bt[idx];
      hz_if.hz_left   = bl[idx];
      hz_if.hz_bottom = bb[idx];
      hz_if.hz_right  = br[idx];
      start = poke;
      if (poke) num_hazards = 4'($urandom_range(0, 15));
      w = v && hz_if.hz_ready;
      @(posedge clk); #1;
      if (w) idx++;
      guard++;
    end
    hz_if.hz_valid = 1'b0;
    start          = 1'b0;
    check({tag, "_beats"}, 32'(idx), 32'(n));
    check({tag, "_ready_low"}, 32'(hz_if.hz_ready), 32'd0);
    lat = 0;
    while (!vec_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), (n == 0) ? 32'd1 : 32'd3);
    check({tag, "_vec1"}, 32'(vec1), 32'(ev[15:0]));
    check({tag, "_vec2"}, 32'(vec2), 32'(ev[31:16]));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    if (n > 0) check({tag, "_bad"}, 32'(bad_count), 32'(eb));
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(vec_valid), 32'd0);
    check({tag, "_vec1_hold"}, 32'(vec1), 32'(ev[15:0]));
  endtask

  task automatic req037_boxes();
    set_box(0, 10, 20, 200, 300);
    set_box(1, 300, 900, 900, 1230);
  endtask

  initial begin
    int n;
    rst               = 1'b1;
    start             = 1'b0;
    num_hazards       = '0;
    hz_if.hz_valid    = 1'b0;
    hz_if.hz_top      = '0;
    hz_if.hz_left     = '0;
    hz_if.hz_bottom   = '0;
    hz_if.hz_right    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec1", 32'(vec1), 32'd0);
    check("rst_vec2", 32'(vec2), 32'd0);
    check("rst_vec_valid", 32'(vec_valid), 32'd0);
    check("rst_ready", 32'(hz_if.hz_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bad", 32'(bad_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    req037_boxes();
    run_frame(2, 1'b0, 1'b0, "two_box");
    check("two_box_const_vec1", 32'(vec1), 32'h0707);
    check("two_box_const_vec2", 32'(vec2), 32'h8080);
    check("two_box_const_bad", 32'(bad_count), 32'd0);

    run_frame(0, 1'b0, 1'b0, "empty");

    set_box(0, 200, 0, 100, 50);
    set_box(1, 0, 0, 10, 10);
    set_box(2, 400, 500, 450, 700);
    run_frame(3, 1'b0, 1'b0, "malformed");
    check("malformed_const_bad", 32'(bad_count), 32'd1);

    set_box(0, 10, 1100, 100, 1200);
    run_frame(1, 1'b0, 1'b0, "off_grid");
    check("off_grid_const_vecs", {vec2, vec1}, 32'd0);

    req037_boxes();
    run_frame(2, 1'b1, 1'b0, "gappy");
    check("gappy_const_vec1", 32'(vec1), 32'h0707);

    for (int i = 0; i < 15; i++) set_box(i, 100 + i, 10, 50, 20);
    run_frame(15, 1'b0, 1'b0, "all_bad");

    // reset in the middle of a frame with results already published
    req037_boxes();
    start       = 1'b1;
    num_hazards = 4'd2;
    @(posedge clk); #1;
    start           = 1'b0;
    hz_if.hz_valid  = 1'b1;
    hz_if.hz_top    = bt[0];
    hz_if.hz_left   = bl[0];
    hz_if.hz_bottom = bb[0];
    hz_if.hz_right  = br[0];
    @(posedge clk); #1;
    check("midrst_ready_before", 32'(hz_if.hz_ready), 32'd1);
    hz_if.hz_valid = 1'b0;
    rst            = 1'b1;
    @(posedge clk); #1;
    check("midrst_vec1", 32'(vec1), 32'd0);
    check("midrst_vec2", 32'(vec2), 32'd0);
    check("midrst_vec_valid", 32'(vec_valid), 32'd0);
    check("midrst_ready", 32'(hz_if.hz_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bad", 32'(bad_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(2, 1'b0, 1'b1, "after_rst");

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        bt[i] = 11'($urandom_range(0, 600));
        bb[i] = 11'($urandom_range(0, 1100));
        bl[i] = 11'($urandom_range(0, 1150));
        br[i] = 11'($urandom_range(0, 2047));
        if ((bb[i] < bt[i] || br[i] < bl[i]) && (bt[i] >= 11'd512 || bl[i] >= 11'd1024)) begin
          bb[i] = bt[i];
          br[i] = bl[i];
        end
      end
      run_frame(n, f % 5 == 0, f % 3 == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
